// File: rtl/cic_hb_dec2.sv
// Half-band decimate-by-2 compensation stage behind the CIC decimator.
// Fixed 7-tap kernel [-1 0 9 16 9 0 -1]/32. Every second accepted sample
// starts a four-step shift-add evaluation that produces one rounded,
// saturated output, held until the downstream handshake completes.
//
// state | meaning
// IDLE  | accepting input samples; a trigger accept starts a computation
// OUTER | acc <- -(d0 + d6)
// MID   | acc <- acc + 9*(d2 + d4)
// CTR   | acc <- acc + 16*d3
// RND   | round, saturate and register the output
// HOLD  | output valid, waiting for out_ready
module cic_hb_dec2 #(
    parameter int IW = 32,
    parameter int OW = 32
) (
    input  logic          clko,
    input  logic          rst,
    input  logic [IW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    // Six guard bits cover the worst-case kernel magnitude (36x full scale).
    localparam int AW = IW + 6;
    localparam logic signed [AW-1:0] RND_BIAS = AW'(16);
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, OUTER, MID, CTR, RND, HOLD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        dly [7];
    logic                 ph;
    logic signed [AW-1:0] acc;
    logic                 accept;
    logic signed [AW-1:0] outer_sum;
    logic signed [AW-1:0] mid_sum;
    logic signed [AW-1:0] mid_x9;
    logic signed [AW-1:0] ctr_x16;
    logic signed [AW-1:0] rnd_sum;
    logic signed [AW-1:0] rnd_shr;
    logic [OW-1:0]        sat_val;

    function automatic logic signed [AW-1:0] sext(input logic [IW-1:0] x);
        return {{(AW-IW){x[IW-1]}}, x};
    endfunction

    assign in_ready = (state == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    // Shift-add partial products; the delay line is frozen outside IDLE.
    assign outer_sum = sext(dly[0]) + sext(dly[6]);
    assign mid_sum   = sext(dly[2]) + sext(dly[4]);
    assign mid_x9    = (mid_sum <<< 3) + mid_sum;
    assign ctr_x16   = sext(dly[3]) <<< 4;
    assign rnd_sum   = acc + RND_BIAS;
    assign rnd_shr   = rnd_sum >>> 5;

    // Clamp the rounded result into the signed output range.
    always_comb begin
        sat_val = rnd_shr[OW-1:0];
        if (rnd_shr > SAT_HI) begin
            sat_val = SAT_HI[OW-1:0];
        end else if (rnd_shr < SAT_LO) begin
            sat_val = SAT_LO[OW-1:0];
        end
    end

    // State register.
    always_ff @(posedge clko) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a trigger is an accept while ph is set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && ph) state_nxt = OUTER;
            OUTER:   state_nxt = MID;
            MID:     state_nxt = CTR;
            CTR:     state_nxt = RND;
            RND:     state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Delay line, phase, accumulator and output registers.
    always_ff @(posedge clko) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                dly[i] <= '0;
            end
            ph        <= 1'b0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 6; i > 0; i--) begin
                    dly[i] <= dly[i-1];
                end
                dly[0] <= in_data;
                ph     <= ~ph;
            end
            case (state)
                OUTER: acc <= -outer_sum;
                MID:   acc <= acc + mid_x9;
                CTR:   acc <= acc + ctr_x16;
                RND: begin
                    out_data  <= sat_val;
                    out_valid <= 1'b1;
                end
                HOLD:  if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
